// File: rtl/tty_ctrl_pkg.sv
// Shared constants for the TTY MMIO controller: register map, STATUS/CTRL bit
// positions, reset value of CTRL and the RX/TX handshake state encodings.
package tty_ctrl_pkg;

  localparam logic [1:0] ADDR_DATA   = 2'd0;
  localparam logic [1:0] ADDR_STATUS = 2'd1;
  localparam logic [1:0] ADDR_CTRL   = 2'd2;

  localparam int ST_RX_VALID = 0;
  localparam int ST_RX_FULL  = 1;
  localparam int ST_TX_BUSY  = 2;
  localparam int ST_TXOVR    = 3;
  localparam int ST_DTR      = 4;

  localparam int CTRL_RX_EN  = 0;
  localparam int CTRL_IRQ_EN = 1;

  localparam logic [1:0] CTRL_RESET = 2'b01;

  typedef enum logic [2:0] {
    R_IDLE,
    R_SETTLE,
    R_CAPTURE,
    R_ACK,
    R_GAP
  } rx_state_e;

  typedef enum logic [1:0] {
    T_IDLE,
    T_SETUP,
    T_STROBE,
    T_DONE
  } tx_state_e;

endpackage

// File: rtl/tty_rx_fifo.sv
// Small synchronous FIFO holding received characters; the head is visible
// combinationally so a DATA load returns it in the same cycle.
module tty_rx_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 8
) (
  input  logic         clk,
  input  logic         srst,
  input  logic         push,
  input  logic [W-1:0] wdata,
  input  logic         pop,
  output logic [W-1:0] head,
  output logic         full,
  output logic         empty
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic          do_push, do_pop;

  assign full    = (count_q == (AW+1)'(DEPTH));
  assign empty   = (count_q == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign head    = mem_q[rd_ptr_q];

  // Power-of-two depth lets the pointers wrap by plain overflow.
  always_comb begin
    wr_ptr_d = do_push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = do_pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
    count_d  = count_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
  end

  always_ff @(posedge clk) begin
    if (srst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata;
  end

endmodule

// File: rtl/tty_mmio_ctrl.sv
// Memory-mapped TTY controller: RTS/CTS receive handshake into a small FIFO,
// DTR/DSR transmit handshake from a holding register, plus STATUS/CTRL/IRQ.
module tty_mmio_ctrl
  import tty_ctrl_pkg::*;
#(
  parameter int RX_DEPTH = 4,
  parameter int SETTLE   = 10,
  parameter int STROBE   = 2
) (
  input  logic       CK,
  input  logic       CLR,
  input  logic       CS,
  input  logic       WE,
  input  logic [1:0] ADDR,
  input  logic [7:0] WDATA,
  output logic [7:0] RDATA,
  output logic       IRQ,
  input  logic [7:0] TD,
  input  logic       RTS,
  output logic       CTS,
  output logic [7:0] RD,
  output logic       DSR,
  input  logic       DTR
);

  localparam int RCW = $clog2((SETTLE > STROBE ? SETTLE : STROBE) + 1);
  localparam int TCW = $clog2(STROBE + 1);

  rx_state_e    rx_state_q, rx_state_d;
  tx_state_e    tx_state_q, tx_state_d;
  logic [RCW-1:0] rx_cnt_q, rx_cnt_d;
  logic [TCW-1:0] tx_cnt_q, tx_cnt_d;
  logic [7:0]   rd_q, rd_d;
  logic [1:0]   ctrl_q, ctrl_d;
  logic         txovr_q, txovr_d;
  logic         cts_q, cts_d;
  logic         dsr_q, dsr_d;
  logic         irq_q, irq_d;

  logic         rd_access, wr_access, data_wr;
  logic         fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [7:0]   fifo_head;
  logic [7:0]   status;

  assign rd_access = CS & ~WE;
  assign wr_access = CS & WE;
  assign data_wr   = wr_access & (ADDR == ADDR_DATA);
  assign fifo_pop  = rd_access & (ADDR == ADDR_DATA);

  tty_rx_fifo #(
    .DEPTH (RX_DEPTH),
    .W     (8)
  ) u_rx_fifo (
    .clk   (CK),
    .srst  (CLR),
    .push  (fifo_push),
    .wdata (TD),
    .pop   (fifo_pop),
    .head  (fifo_head),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // Receive handshake; rx_en only gates the start of a new sequence.
  always_comb begin
    rx_state_d = rx_state_q;
    rx_cnt_d   = rx_cnt_q;
    fifo_push  = 1'b0;
    case (rx_state_q)
      R_IDLE: begin
        if (RTS && ctrl_q[CTRL_RX_EN] && !fifo_full) begin
          rx_state_d = R_SETTLE;
          rx_cnt_d   = '0;
        end
      end
      R_SETTLE: begin
        if (!RTS) begin
          rx_state_d = R_IDLE;
        end else if (rx_cnt_q == RCW'(SETTLE - 1)) begin
          rx_state_d = R_CAPTURE;
        end else begin
          rx_cnt_d = rx_cnt_q + 1'b1;
        end
      end
      R_CAPTURE: begin
        fifo_push  = 1'b1;
        rx_state_d = R_ACK;
        rx_cnt_d   = '0;
      end
      R_ACK: begin
        if (rx_cnt_q == RCW'(STROBE - 1)) rx_state_d = R_GAP;
        else rx_cnt_d = rx_cnt_q + 1'b1;
      end
      R_GAP:   rx_state_d = R_IDLE;
      default: rx_state_d = R_IDLE;
    endcase
    cts_d = (rx_state_d == R_ACK);
  end

  always_comb begin
    tx_state_d = tx_state_q;
    tx_cnt_d   = tx_cnt_q;
    rd_d       = rd_q;
    case (tx_state_q)
      T_IDLE: begin
        if (data_wr) begin
          rd_d       = WDATA;
          tx_state_d = T_SETUP;
        end
      end
      T_SETUP: begin
        if (DTR) begin
          tx_state_d = T_STROBE;
          tx_cnt_d   = '0;
        end
      end
      T_STROBE: begin
        if (tx_cnt_q == TCW'(STROBE - 1)) tx_state_d = T_DONE;
        else tx_cnt_d = tx_cnt_q + 1'b1;
      end
      T_DONE:  tx_state_d = T_IDLE;
      default: tx_state_d = T_IDLE;
    endcase
    dsr_d = (tx_state_d == T_STROBE);
  end

  always_comb begin
    txovr_d = txovr_q;
    ctrl_d  = ctrl_q;
    if (data_wr && tx_state_q != T_IDLE) begin
      txovr_d = 1'b1;
    end else if (wr_access && ADDR == ADDR_STATUS && WDATA[ST_TXOVR]) begin
      txovr_d = 1'b0;
    end
    if (wr_access && ADDR == ADDR_CTRL) ctrl_d = WDATA[1:0];
    irq_d = ctrl_q[CTRL_IRQ_EN] & ~fifo_empty;
  end

  always_comb begin
    status              = '0;
    status[ST_RX_VALID] = ~fifo_empty;
    status[ST_RX_FULL]  = fifo_full;
    status[ST_TX_BUSY]  = (tx_state_q != T_IDLE);
    status[ST_TXOVR]    = txovr_q;
    status[ST_DTR]      = DTR;
    case (ADDR)
      ADDR_DATA:   RDATA = fifo_empty ? 8'h00 : fifo_head;
      ADDR_STATUS: RDATA = status;
      ADDR_CTRL:   RDATA = {6'b0, ctrl_q};
      default:     RDATA = 8'h00;
    endcase
  end

  always_ff @(posedge CK) begin
    if (CLR) begin
      rx_state_q <= R_IDLE;
      tx_state_q <= T_IDLE;
      rx_cnt_q   <= '0;
      tx_cnt_q   <= '0;
      rd_q       <= 8'h00;
      ctrl_q     <= CTRL_RESET;
      txovr_q    <= 1'b0;
      cts_q      <= 1'b0;
      dsr_q      <= 1'b0;
      irq_q      <= 1'b0;
    end else begin
      rx_state_q <= rx_state_d;
      tx_state_q <= tx_state_d;
      rx_cnt_q   <= rx_cnt_d;
      tx_cnt_q   <= tx_cnt_d;
      rd_q       <= rd_d;
      ctrl_q     <= ctrl_d;
      txovr_q    <= txovr_d;
      cts_q      <= cts_d;
      dsr_q      <= dsr_d;
      irq_q      <= irq_d;
    end
  end

  assign CTS = cts_q;
  assign DSR = dsr_q;
  assign RD  = rd_q;
  assign IRQ = irq_q;

endmodule

// File: tb/tb_tty_mmio_ctrl.sv
// Bench for tty_mmio_ctrl: a timeline/queue model checked every cycle, plus
// directed scenarios with hand-computed literal expectations.
module tb_tty_mmio_ctrl;

  localparam int DEPTH  = 4;
  localparam int SETTLE = 10;
  localparam int STROBE = 2;

  logic       CK = 1'b0;
  logic       CLR = 1'b1;
  logic       CS = 1'b0;
  logic       WE = 1'b0;
  logic [1:0] ADDR = 2'd0;
  logic [7:0] WDATA = 8'h00;
  logic [7:0] TD = 8'h00;
  logic       RTS = 1'b0;
  logic       DTR = 1'b0;
  logic [7:0] RDATA;
  logic       IRQ;
  logic       CTS;
  logic [7:0] RD;
  logic       DSR;

  int ntests = 0;
  int nfail  = 0;

  always #5 CK = ~CK;

  tty_mmio_ctrl #(
    .RX_DEPTH (DEPTH),
    .SETTLE   (SETTLE),
    .STROBE   (STROBE)
  ) dut (
    .CK    (CK),
    .CLR   (CLR),
    .CS    (CS),
    .WE    (WE),
    .ADDR  (ADDR),
    .WDATA (WDATA),
    .RDATA (RDATA),
    .IRQ   (IRQ),
    .TD    (TD),
    .RTS   (RTS),
    .CTS   (CTS),
    .RD    (RD),
    .DSR   (DSR),
    .DTR   (DTR)
  );

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    ntests++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got 0x%02h expected 0x%02h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: received bytes in a queue; each handshake is a position on a
  // timeline (rx_t / tx_t, -1 = not in progress).
  logic [7:0] q[$];
  int         rx_t = -1;
  int         tx_t = -1;
  logic [7:0] m_rd = 8'h00;
  logic       m_txovr = 1'b0;
  logic [1:0] m_ctrl = 2'b01;
  logic       m_irq = 1'b0;
  bit         model_live = 1'b0;

  logic       s_clr, s_cs, s_we, s_rts, s_dtr;
  logic [1:0] s_addr;
  logic [7:0] s_wdata, s_td;
  int         n0;
  bit         busy0, irq_next;

  function automatic logic [7:0] exp_rdata();
    case (ADDR)
      2'd0:    return (q.size() > 0) ? q[0] : 8'h00;
      2'd1:    return {3'b000, DTR, m_txovr, tx_t >= 0, q.size() == DEPTH, q.size() > 0};
      2'd2:    return {6'b0, m_ctrl};
      default: return 8'h00;
    endcase
  endfunction

  always @(posedge CK) begin
    s_clr = CLR; s_cs = CS; s_we = WE; s_addr = ADDR; s_wdata = WDATA;
    s_td = TD; s_rts = RTS; s_dtr = DTR;
    if (s_clr) begin
      q.delete();
      rx_t = -1; tx_t = -1; m_rd = 8'h00; m_txovr = 1'b0;
      m_ctrl = 2'b01; m_irq = 1'b0; model_live = 1'b1;
    end else if (model_live) begin
      n0       = q.size();
      busy0    = (tx_t >= 0);
      irq_next = m_ctrl[1] && (n0 > 0);
      if (s_cs && !s_we && s_addr == 2'd0 && n0 > 0) void'(q.pop_front());
      if (rx_t < 0) begin
        if (s_rts && m_ctrl[0] && n0 < DEPTH) rx_t = 0;
      end else if (rx_t < SETTLE && !s_rts) begin
        rx_t = -1;
      end else begin
        if (rx_t == SETTLE) q.push_back(s_td);
        rx_t++;
        if (rx_t > SETTLE + STROBE + 1) rx_t = -1;
      end
      if (tx_t == 0) begin
        if (s_dtr) tx_t = 1;
      end else if (tx_t > 0) begin
        tx_t++;
        if (tx_t > STROBE + 1) tx_t = -1;
      end
      if (s_cs && s_we && s_addr == 2'd0) begin
        if (!busy0) begin m_rd = s_wdata; tx_t = 0; end
        else m_txovr = 1'b1;
      end
      if (s_cs && s_we && s_addr == 2'd1 && s_wdata[3]) m_txovr = 1'b0;
      if (s_cs && s_we && s_addr == 2'd2) m_ctrl = s_wdata[1:0];
      m_irq = irq_next;
    end
    #1;
    if (model_live) begin
      check("cyc_cts", {7'b0, CTS}, {7'b0, (rx_t >= SETTLE + 1 && rx_t <= SETTLE + STROBE)});
      check("cyc_dsr", {7'b0, DSR}, {7'b0, (tx_t >= 1 && tx_t <= STROBE)});
      check("cyc_rd", RD, m_rd);
      check("cyc_irq", {7'b0, IRQ}, {7'b0, m_irq});
      check("cyc_rdata", RDATA, exp_rdata());
    end
  end

  task automatic bus_read(input logic [1:0] a, output logic [7:0] d);
    CS = 1'b1; WE = 1'b0; ADDR = a;
    #1 d = RDATA;
    @(negedge CK);
    CS = 1'b0; ADDR = 2'd0;
  endtask

  task automatic rd_check(input string name, input logic [1:0] a, input logic [7:0] exp);
    logic [7:0] d;
    bus_read(a, d);
    check(name, d, exp);
  endtask

  task automatic bus_write(input logic [1:0] a, input logic [7:0] d);
    CS = 1'b1; WE = 1'b1; ADDR = a; WDATA = d;
    @(negedge CK);
    CS = 1'b0; WE = 1'b0; ADDR = 2'd0; WDATA = 8'h00;
  endtask

  task automatic wait_cts_high(output int n);
    n = 0;
    while (CTS !== 1'b1 && n < 60) begin
      @(posedge CK); #1; n++;
    end
    ntests++;
    if (CTS !== 1'b1) begin
      nfail++;
      $display("FAIL cts_wait: CTS still 0 after %0d cycles, required 1", n);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("[TB] %0d tests run, %0d failed", ntests, nfail + 1);
    $fatal(1);
  end

  initial begin
    int   n, w, acks, guard;
    bit   seen, prev;
    repeat (3) @(negedge CK);
    CLR = 1'b0;

    // Reset state
    check("rst_cts", {7'b0, CTS}, 8'h00);
    check("rst_dsr", {7'b0, DSR}, 8'h00);
    check("rst_rd", RD, 8'h00);
    rd_check("rst_status", 2'd1, 8'h00);
    rd_check("rst_ctrl", 2'd2, 8'h01);
    rd_check("rst_data", 2'd0, 8'h00);
    rd_check("reserved", 2'd3, 8'h00);

    // Receive one character
    TD = 8'h41; RTS = 1'b1;
    wait_cts_high(n);
    check("cts_latency", 8'(n - 1), 8'd11);
    w = 0;
    while (CTS === 1'b1 && w < 10) begin @(posedge CK); #1; w++; end
    check("cts_width", 8'(w), 8'd2);
    @(negedge CK); RTS = 1'b0;
    rd_check("rx1_status", 2'd1, 8'h01);
    rd_check("rx1_data", 2'd0, 8'h41);
    rd_check("rx1_status_after", 2'd1, 8'h00);

    // RTS glitch shorter than the settle window
    RTS = 1'b1;
    repeat (5) @(negedge CK);
    RTS = 1'b0;
    seen = 1'b0;
    repeat (20) begin @(negedge CK); if (CTS) seen = 1'b1; end
    check("glitch_cts", {7'b0, seen}, 8'h00);
    rd_check("glitch_status", 2'd1, 8'h00);

    // Fill the FIFO, observe back-pressure, then drain
    TD = 8'h30; RTS = 1'b1; acks = 0; prev = 1'b0; guard = 0;
    while (acks < 4 && guard < 200) begin
      @(negedge CK); guard++;
      if (CTS && !prev) begin acks++; TD = TD + 8'h01; end
      prev = CTS;
    end
    check("full_acks", 8'(acks), 8'd4);
    repeat (5) @(negedge CK);
    seen = 1'b0;
    repeat (25) begin @(negedge CK); if (CTS) seen = 1'b1; end
    check("full_cts_hold", {7'b0, seen}, 8'h00);
    rd_check("full_status", 2'd1, 8'h03);
    rd_check("full_pop0", 2'd0, 8'h30);
    prev = 1'b0; guard = 0;
    while (acks < 5 && guard < 60) begin
      @(negedge CK); guard++;
      if (CTS && !prev) begin acks++; RTS = 1'b0; end
      prev = CTS;
    end
    check("full_ack5", 8'(acks), 8'd5);
    repeat (4) @(negedge CK);
    rd_check("drain_0", 2'd0, 8'h31);
    rd_check("drain_1", 2'd0, 8'h32);
    rd_check("drain_2", 2'd0, 8'h33);
    rd_check("drain_3", 2'd0, 8'h34);
    rd_check("drain_status", 2'd1, 8'h00);

    // Transmit
    bus_write(2'd0, 8'h61);
    check("tx_rd", RD, 8'h61);
    check("tx_dsr_idle", {7'b0, DSR}, 8'h00);
    rd_check("tx_status_busy", 2'd1, 8'h04);
    repeat (5) @(negedge CK);
    check("tx_dsr_wait_dtr", {7'b0, DSR}, 8'h00);
    bus_write(2'd0, 8'h55);
    check("tx_rd_unchanged", RD, 8'h61);
    rd_check("tx_status_ovr", 2'd1, 8'h0C);
    bus_write(2'd1, 8'h08);
    rd_check("tx_ovr_clear", 2'd1, 8'h04);
    DTR = 1'b1;
    n = 0;
    while (DSR !== 1'b1 && n < 20) begin @(posedge CK); #1; n++; end
    check("dsr_latency", 8'(n), 8'd1);
    w = 0;
    while (DSR === 1'b1 && w < 10) begin @(posedge CK); #1; w++; end
    check("dsr_width", 8'(w), 8'd2);
    repeat (2) @(negedge CK);
    rd_check("tx_status_done", 2'd1, 8'h10);
    check("tx_rd_hold", RD, 8'h61);
    DTR = 1'b0;

    // IRQ
    bus_write(2'd2, 8'h03);
    rd_check("irq_ctrl", 2'd2, 8'h03);
    TD = 8'h7A; RTS = 1'b1;
    wait_cts_high(n);
    check("irq_at_push", {7'b0, IRQ}, 8'h00);
    @(posedge CK); #1;
    check("irq_after_push", {7'b0, IRQ}, 8'h01);
    @(negedge CK); RTS = 1'b0;
    repeat (3) @(negedge CK);
    rd_check("irq_data", 2'd0, 8'h7A);
    @(negedge CK);
    check("irq_cleared", {7'b0, IRQ}, 8'h00);

    // Reset in the middle of the acknowledge
    TD = 8'h55; RTS = 1'b1;
    wait_cts_high(n);
    @(negedge CK); CLR = 1'b1; RTS = 1'b0;
    @(negedge CK); CLR = 1'b0;
    check("clr_cts", {7'b0, CTS}, 8'h00);
    check("clr_irq", {7'b0, IRQ}, 8'h00);
    rd_check("clr_status", 2'd1, 8'h00);
    rd_check("clr_ctrl", 2'd2, 8'h01);
    rd_check("clr_data", 2'd0, 8'h00);

    repeat (3) @(negedge CK);
    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule
